mem_responder: RTL

- Memory-side responder for the CPU's memory handshake (enable, rw, address, write data, mfc).
- Holds a word-addressed RAM and latches each request from the CPU.
- Waits a programmable latency, then performs the read or write and raises mfc (memory function complete).
- Sits opposite the CPU top level and replaces the bench-driven memory. Also has a side load port for preloading programs.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_array.sv | 36 +++
 rtl/mem_responder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory handshake: FSM states, rw encoding, defaults.
// Also used by the CPU-side FSMs for their rw outputs.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    localparam int DEFAULT_DEPTH   = 1024;
    localparam int DEFAULT_LATENCY = 3;

    // Addresses are compared at 32 bits so any AW up to 32 works without wrap.
    function automatic logic inRange(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory four-phase handshake bus plus the side preload port.
// master = CPU/loader side, slave = memory responder.
interface mem_responder_if #(
    parameter int AW = 16
);
    logic          enable;
    logic          rw;
    logic [AW-1:0] address;
    logic [15:0]   dataIn;
    logic [15:0]   dataOut;
    logic          mfc;
    logic          errAddr;
    logic          busyOut;
    logic          loadEn;
    logic [AW-1:0] loadAddr;
    logic [15:0]   loadData;

    modport master (
        output enable, rw, address, dataIn, loadEn, loadAddr, loadData,
        input  dataOut, mfc, errAddr, busyOut
    );

    modport slave (
        input  enable, rw, address, dataIn, loadEn, loadAddr, loadData,
        output dataOut, mfc, errAddr, busyOut
    );
endinterface

// File: rtl/mem_array.sv
// Single-port word RAM with write enable and registered read port.
// Latency: write lands on the edge, read data visible after the edge; no backpressure.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic          clr,
    input  logic [IW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: latches a CPU request, waits LATENCY cycles, accesses RAM, raises mfc.
// Latency: mfc visible after edge E0+LATENCY+1; mfc held until enable drops (four-phase).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int AW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int IW = $clog2(DEPTH);

    memState_t     state, nextState;
    logic [3:0]    counter;
    logic [AW-1:0] latAddr;
    logic          latRw;
    logic [15:0]   latData;
    logic          mfcReg;
    logic          errReg;

    logic          latInRange;
    logic          capture;
    logic          complete;
    logic          arrWe, arrRe, arrClr;
    logic [IW-1:0] arrAddr;
    logic [15:0]   arrWdata;
    logic [15:0]   arrRdata;

    assign latInRange = inRange(32'(latAddr), DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The single RAM port is shared: preload owns it in IDLE, the request on completion.
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        complete  = 1'b0;
        arrWe     = 1'b0;
        arrRe     = 1'b0;
        arrClr    = 1'b0;
        arrAddr   = latAddr[IW-1:0];
        arrWdata  = latData;
        case (state)
            IDLE: begin
                if (bus.loadEn) begin
                    arrWe    = inRange(32'(bus.loadAddr), DEPTH);
                    arrAddr  = bus.loadAddr[IW-1:0];
                    arrWdata = bus.loadData;
                end else if (bus.enable) begin
                    capture   = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (!bus.enable) begin
                    nextState = IDLE;
                end else if (counter == 4'd0) begin
                    complete  = 1'b1;
                    nextState = DONE;
                    arrWe     = latInRange && (latRw == MEM_WRITE);
                    arrRe     = latInRange && (latRw == MEM_READ);
                    arrClr    = !latInRange;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            latAddr <= '0;
            latRw   <= MEM_READ;
            latData <= '0;
            mfcReg  <= 1'b0;
            errReg  <= 1'b0;
        end else begin
            if (capture) begin
                latAddr <= bus.address;
                latRw   <= bus.rw;
                latData <= bus.dataIn;
                counter <= 4'(LATENCY);
            end else if (state == WAIT && bus.enable && counter != 4'd0) begin
                counter <= counter - 4'd1;
            end
            if (complete) begin
                mfcReg <= 1'b1;
                errReg <= !latInRange;
            end else if (state == DONE && !bus.enable) begin
                mfcReg <= 1'b0;
                errReg <= 1'b0;
            end
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arrWe),
        .re    (arrRe),
        .clr   (arrClr),
        .addr  (arrAddr),
        .wdata (arrWdata),
        .rdata (arrRdata)
    );

    assign bus.dataOut = arrRdata;
    assign bus.mfc     = mfcReg;
    assign bus.errAddr = errReg;
    assign bus.busyOut = (state != IDLE);

endmodule
